// File: rtl/delay_alloc_ctrl_if.sv
// Request, memory-clear and descriptor signals of delay_alloc_ctrl.
// slave is the allocator's view; master is the command controller / memory side.
interface delay_alloc_ctrl_if #(
  parameter int data_width     = 16,
  parameter int mem_addr_width = 16,
  parameter int n_buffers      = 16
);
  localparam int idx_w = $clog2(n_buffers);
  localparam int cnt_w = idx_w + 1;

  logic [1:0]                alloc_req;
  logic [data_width-1:0]     alloc_size;
  logic [2*data_width-1:0]   alloc_delay_init;
  logic [1:0]                free_req;
  logic                      mem_clr_valid;
  logic [mem_addr_width-1:0] mem_clr_addr;
  logic                      mem_clr_ready;
  logic [1:0]                desc_write;
  logic [idx_w-1:0]          desc_index;
  logic [mem_addr_width-1:0] desc_base;
  logic [data_width-1:0]     desc_size;
  logic [2*data_width-1:0]   desc_delay;
  logic                      delay_clamped;
  logic [1:0]                alloc_fail;
  logic                      busy;
  logic [cnt_w-1:0]          pipeline_n_buffers [1:0];

  modport slave (
    input  alloc_req, alloc_size, alloc_delay_init, free_req, mem_clr_ready,
    output mem_clr_valid, mem_clr_addr, desc_write, desc_index, desc_base,
           desc_size, desc_delay, delay_clamped, alloc_fail, busy, pipeline_n_buffers
  );

  modport master (
    output alloc_req, alloc_size, alloc_delay_init, free_req, mem_clr_ready,
    input  mem_clr_valid, mem_clr_addr, desc_write, desc_index, desc_base,
           desc_size, desc_delay, delay_clamped, alloc_fail, busy, pipeline_n_buffers
  );
endinterface

// File: rtl/delay_alloc_ctrl.sv
// Bump-pointer delay buffer allocator; descriptor N+2 cycles after the request (2 without DELAY_ALLOC_CLEAR_EN).
// Clear stalls on mem_clr_ready; one extra request waits in a pending slot, further ones fail.
module delay_alloc_ctrl #(
  parameter int data_width     = 16,
  parameter int mem_addr_width = 16,
  parameter int n_buffers      = 16
) (
  input  logic              clk,
  input  logic              reset,
  delay_alloc_ctrl_if.slave bus
);
  localparam int idx_w = $clog2(n_buffers);
  localparam int cnt_w = idx_w + 1;
  localparam int dw2   = 2 * data_width;
  localparam int ext_w = ((data_width > mem_addr_width) ? data_width : mem_addr_width) + 1;
  localparam logic [ext_w-1:0] half_words = {{(ext_w-1){1'b0}}, 1'b1} << (mem_addr_width - 1);
  localparam logic [cnt_w-1:0] max_bufs   = cnt_w'(n_buffers);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    COMMIT = 2'd2
`ifdef DELAY_ALLOC_CLEAR_EN
    , CLEAR = 2'd3
`endif
  } state_t;

  state_t state_q, state_d;

  logic [mem_addr_width-1:0] ptr_q [2];
  logic [mem_addr_width-1:0] ptr_d [2];
  logic [cnt_w-1:0]          cnt_q [2];
  logic [cnt_w-1:0]          cnt_d [2];

  logic                  pend_vld_q, pend_vld_d;
  logic                  pend_p_q, pend_p_d;
  logic [data_width-1:0] pend_size_q, pend_size_d;
  logic [dw2-1:0]        pend_delay_q, pend_delay_d;

  logic                  cur_p_q, cur_p_d;
  logic [data_width-1:0] cur_size_q, cur_size_d;
  logic [dw2-1:0]        cur_delay_q, cur_delay_d;

  logic [1:0]                desc_write_q, desc_write_d;
  logic [idx_w-1:0]          desc_index_q, desc_index_d;
  logic [mem_addr_width-1:0] desc_base_q, desc_base_d;
  logic [data_width-1:0]     desc_size_q, desc_size_d;
  logic [dw2-1:0]            desc_delay_q, desc_delay_d;
  logic                      delay_clamped_q, delay_clamped_d;
  logic [1:0]                alloc_fail_q, alloc_fail_d;
  logic                      busy_q, busy_d;

`ifdef DELAY_ALLOC_CLEAR_EN
  logic                      mem_clr_valid_q, mem_clr_valid_d;
  logic [mem_addr_width-1:0] clr_addr_q, clr_addr_d;
  logic [data_width-1:0]     clr_cnt_q, clr_cnt_d;
`endif

  logic [1:0]                req;
  logic                      pend_live, cur_dead, idle, slot_free;
  logic                      take_vld, take_p;
  logic [data_width-1:0]     take_size;
  logic [dw2-1:0]            take_delay;
  logic [mem_addr_width-1:0] cur_ptr, cur_base;
  logic [cnt_w-1:0]          cur_cnt;
  logic [data_width-1:0]     size_m1;
  logic                      clamp, chk_fail, load_desc;

  always_comb begin
    state_d         = state_q;
    pend_p_d        = pend_p_q;
    pend_size_d     = pend_size_q;
    pend_delay_d    = pend_delay_q;
    cur_p_d         = cur_p_q;
    cur_size_d      = cur_size_q;
    cur_delay_d     = cur_delay_q;
    desc_write_d    = 2'b00;
    desc_index_d    = desc_index_q;
    desc_base_d     = desc_base_q;
    desc_size_d     = desc_size_q;
    desc_delay_d    = desc_delay_q;
    delay_clamped_d = 1'b0;
    alloc_fail_d    = 2'b00;
    load_desc       = 1'b0;
`ifdef DELAY_ALLOC_CLEAR_EN
    mem_clr_valid_d = mem_clr_valid_q;
    clr_addr_d      = clr_addr_q;
    clr_cnt_d       = clr_cnt_q;
`endif

    cur_ptr  = ptr_q[cur_p_q];
    cur_cnt  = cnt_q[cur_p_q];
    cur_base = {cur_p_q, cur_ptr[mem_addr_width-2:0]};
    size_m1  = cur_size_q - data_width'(1);
    clamp    = cur_delay_q > dw2'(size_m1);
    chk_fail = (cur_size_q == '0) || (cur_cnt == max_bufs) ||
               ((ext_w'(cur_ptr) + ext_w'(cur_size_q)) > half_words);

    // A free wins over everything belonging to its pipeline: strobes, pending entry, in-flight work.
    req       = bus.alloc_req & ~bus.free_req;
    pend_live = pend_vld_q && !bus.free_req[pend_p_q];
    cur_dead  = bus.free_req[cur_p_q];
    idle      = (state_q == IDLE);

    for (int p = 0; p < 2; p++) begin
      ptr_d[p] = bus.free_req[p] ? '0 : ptr_q[p];
      cnt_d[p] = bus.free_req[p] ? '0 : cnt_q[p];
    end

    take_vld    = idle && pend_live;
    take_p      = pend_p_q;
    take_size   = pend_size_q;
    take_delay  = pend_delay_q;
    pend_vld_d  = pend_live && !idle;
    slot_free   = idle || !pend_live;

    for (int p = 0; p < 2; p++) begin
      if (req[p]) begin
        if (idle && !take_vld) begin
          take_vld   = 1'b1;
          take_p     = 1'(p);
          take_size  = bus.alloc_size;
          take_delay = bus.alloc_delay_init;
        end else if (slot_free) begin
          pend_vld_d   = 1'b1;
          pend_p_d     = 1'(p);
          pend_size_d  = bus.alloc_size;
          pend_delay_d = bus.alloc_delay_init;
          slot_free    = 1'b0;
        end else begin
          alloc_fail_d[p] = 1'b1;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (take_vld) begin
          state_d     = CHECK;
          cur_p_d     = take_p;
          cur_size_d  = take_size;
          cur_delay_d = take_delay;
        end
      end
      CHECK: begin
        if (cur_dead) begin
          state_d = IDLE;
        end else if (chk_fail) begin
          alloc_fail_d[cur_p_q] = 1'b1;
          state_d               = IDLE;
        end else begin
`ifdef DELAY_ALLOC_CLEAR_EN
          state_d         = CLEAR;
          clr_addr_d      = cur_base;
          clr_cnt_d       = cur_size_q;
          mem_clr_valid_d = 1'b1;
`else
          state_d   = COMMIT;
          load_desc = 1'b1;
`endif
        end
      end
`ifdef DELAY_ALLOC_CLEAR_EN
      CLEAR: begin
        if (cur_dead) begin
          state_d         = IDLE;
          mem_clr_valid_d = 1'b0;
        end else if (bus.mem_clr_ready) begin
          clr_addr_d = clr_addr_q + mem_addr_width'(1);
          clr_cnt_d  = clr_cnt_q - data_width'(1);
          if (clr_cnt_q == data_width'(1)) begin
            mem_clr_valid_d = 1'b0;
            state_d         = COMMIT;
            load_desc       = 1'b1;
          end
        end
      end
`endif
      COMMIT: begin
        state_d = IDLE;
        if (!cur_dead) begin
          ptr_d[cur_p_q] = cur_ptr + mem_addr_width'(cur_size_q);
          cnt_d[cur_p_q] = cur_cnt + cnt_w'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Descriptor is registered on entry to COMMIT so desc_write lines up with that state.
    if (load_desc) begin
      desc_write_d[cur_p_q] = 1'b1;
      desc_index_d          = cur_cnt[idx_w-1:0];
      desc_base_d           = cur_base;
      desc_size_d           = cur_size_q;
      desc_delay_d          = clamp ? dw2'(size_m1) : cur_delay_q;
      delay_clamped_d       = clamp;
    end

    busy_d = (state_d != IDLE) || pend_vld_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      for (int p = 0; p < 2; p++) begin
        ptr_q[p] <= '0;
        cnt_q[p] <= '0;
      end
      pend_vld_q      <= 1'b0;
      pend_p_q        <= 1'b0;
      pend_size_q     <= '0;
      pend_delay_q    <= '0;
      cur_p_q         <= 1'b0;
      cur_size_q      <= '0;
      cur_delay_q     <= '0;
      desc_write_q    <= 2'b00;
      desc_index_q    <= '0;
      desc_base_q     <= '0;
      desc_size_q     <= '0;
      desc_delay_q    <= '0;
      delay_clamped_q <= 1'b0;
      alloc_fail_q    <= 2'b00;
      busy_q          <= 1'b0;
`ifdef DELAY_ALLOC_CLEAR_EN
      mem_clr_valid_q <= 1'b0;
      clr_addr_q      <= '0;
      clr_cnt_q       <= '0;
`endif
    end else begin
      state_q         <= state_d;
      for (int p = 0; p < 2; p++) begin
        ptr_q[p] <= ptr_d[p];
        cnt_q[p] <= cnt_d[p];
      end
      pend_vld_q      <= pend_vld_d;
      pend_p_q        <= pend_p_d;
      pend_size_q     <= pend_size_d;
      pend_delay_q    <= pend_delay_d;
      cur_p_q         <= cur_p_d;
      cur_size_q      <= cur_size_d;
      cur_delay_q     <= cur_delay_d;
      desc_write_q    <= desc_write_d;
      desc_index_q    <= desc_index_d;
      desc_base_q     <= desc_base_d;
      desc_size_q     <= desc_size_d;
      desc_delay_q    <= desc_delay_d;
      delay_clamped_q <= delay_clamped_d;
      alloc_fail_q    <= alloc_fail_d;
      busy_q          <= busy_d;
`ifdef DELAY_ALLOC_CLEAR_EN
      mem_clr_valid_q <= mem_clr_valid_d;
      clr_addr_q      <= clr_addr_d;
      clr_cnt_q       <= clr_cnt_d;
`endif
    end
  end

`ifdef DELAY_ALLOC_CLEAR_EN
  assign bus.mem_clr_valid = mem_clr_valid_q;
  assign bus.mem_clr_addr  = clr_addr_q;
`else
  logic unused_clr_ready;
  assign unused_clr_ready  = bus.mem_clr_ready;
  assign bus.mem_clr_valid = 1'b0;
  assign bus.mem_clr_addr  = '0;
`endif

  assign bus.desc_write            = desc_write_q;
  assign bus.desc_index            = desc_index_q;
  assign bus.desc_base             = desc_base_q;
  assign bus.desc_size             = desc_size_q;
  assign bus.desc_delay            = desc_delay_q;
  assign bus.delay_clamped         = delay_clamped_q;
  assign bus.alloc_fail            = alloc_fail_q;
  assign bus.busy                  = busy_q;
  assign bus.pipeline_n_buffers[0] = cnt_q[0];
  assign bus.pipeline_n_buffers[1] = cnt_q[1];
endmodule
